// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between instruction
//   fetch (if_*) and data access (dm_*). One transaction at a time:
//   IDLE (arbitrate + latch) -> REQ (mem_req until mem_gnt) -> RESP (wait
//   mem_rvalid) -> IDLE, with a one-cycle done pulse to the owner.
//
//   Ports
//     clk, rst_n                       clock, async active-low reset
//     if_req/if_addr/if_kill           fetch request, address, redirect kill
//     if_rdata/if_done                 fetch data, completion pulse
//     dm_req/dm_we/dm_addr/dm_wdata    data request (load/store)
//     dm_rdata/dm_done                 load data, completion pulse
//     stall_f, stall_m                 hazard stalls (combinational)
//     mem_req/mem_we/mem_addr/mem_wdata  memory request side
//     mem_gnt/mem_rvalid/mem_rdata     memory accept / response
//
//   Build option: MEM_ARB_RR_EN selects round-robin tie breaking with a
//   1-bit last-owner register; without it data always beats fetch.
module mem_port_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_kill,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_done,
   output logic          stall_f,
   output logic          stall_m,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   state_t        r_state;
   logic          r_owner;
   logic          r_we;
   logic          r_killed;
   logic          r_mem_req;
   logic          r_if_done;
   logic          r_dm_done;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_dm_rdata;

   logic w_if_cand;
   logic w_dm_cand;
   logic w_grant_dm;
   logic w_any;

   // A requester whose done bit is up is finishing this cycle; masking it
   // keeps the FSM from re-granting a request the stage is about to drop.
   assign w_if_cand = if_req & ~if_kill & ~r_if_done;
   assign w_dm_cand = dm_req & ~r_dm_done;
   assign w_any     = w_if_cand | w_dm_cand;

`ifdef MEM_ARB_RR_EN
   logic r_last;  // owner of the most recent grant

   // On a tie, whoever was not served last wins.
   assign w_grant_dm = w_dm_cand & (~w_if_cand | (r_last == OWN_IF));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last <= OWN_IF;
      else if (r_state == S_IDLE && w_any)
         r_last <= w_grant_dm ? OWN_DM : OWN_IF;
   end
`else
   // Older instruction (memory stage) drains first.
   assign w_grant_dm = w_dm_cand;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_owner    <= OWN_IF;
         r_we       <= 1'b0;
         r_killed   <= 1'b0;
         r_mem_req  <= 1'b0;
         r_if_done  <= 1'b0;
         r_dm_done  <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
      end else begin
         r_if_done <= 1'b0;
         r_dm_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner   <= w_grant_dm ? OWN_DM : OWN_IF;
                  r_we      <= w_grant_dm & dm_we;
                  r_addr    <= w_grant_dm ? dm_addr : if_addr;
                  r_wdata   <= w_grant_dm ? dm_wdata : '0;
                  r_killed  <= 1'b0;
                  r_mem_req <= 1'b1;
                  r_state   <= S_REQ;
               end
            end
            S_REQ: begin
               // Request is already visible to memory: let it finish, but
               // remember the fetch was abandoned. A same-cycle rvalid is
               // not a legal response here and is ignored.
               if (r_owner == OWN_IF && if_kill)
                  r_killed <= 1'b1;
               if (mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_RESP;
               end
            end
            S_RESP: begin
               if (mem_rvalid) begin
                  if (r_owner == OWN_DM) begin
                     r_dm_done <= 1'b1;
                     if (!r_we)
                        r_dm_rdata <= mem_rdata;
                  end else if (!(r_killed | if_kill)) begin
                     r_if_done  <= 1'b1;
                     r_if_rdata <= mem_rdata;
                  end
                  r_killed <= 1'b0;
                  r_state  <= S_IDLE;
               end else if (r_owner == OWN_IF && if_kill) begin
                  r_killed <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_req & r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_rdata  = r_if_rdata;
   assign if_done   = r_if_done;
   assign dm_rdata  = r_dm_rdata;
   assign dm_done   = r_dm_done;
   assign stall_f   = if_req & ~r_if_done & ~if_kill;
   assign stall_m   = dm_req & ~r_dm_done;

endmodule
